// File: rtl/sync_fifo_ctlr_if.sv
// sync_fifo_ctlr_if
//   Bundles the request, threshold, RAM-control and status signals of the
//   single-clock FIFO controller. Clock and reset stay plain module ports.
//
//   Handshake: a push is taken on a rising clock edge when i_push is high and
//   the FIFO is not full; a pop is taken when i_pop is high and the FIFO is not
//   empty. o_wen / o_ren show, combinationally within the same cycle, whether
//   that cycle's push / pop will be taken. A rejected request is dropped; it is
//   not held pending.
//
//   Modports:
//     master - producer/consumer side: drives requests, thresholds, err_clr
//     slave  - the controller: drives RAM enables/addresses and status
//
//   AW and CW must match the values given to the controller instance.
interface sync_fifo_ctlr_if #(
  parameter int AW = 10,
  parameter int CW = 11
);
  logic          i_push;
  logic          i_pop;
  logic [CW-1:0] i_afull_thr;
  logic [CW-1:0] i_aempty_thr;
  logic          i_err_clr;

  logic          o_wen;
  logic [AW-1:0] o_wptr;
  logic          o_ren;
  logic [AW-1:0] o_rptr;
  logic          o_full;
  logic          o_empty;
  logic          o_almost_full;
  logic          o_almost_empty;
  logic [CW-1:0] o_count;
  logic          o_overflow;
  logic          o_underflow;

  modport master (
    output i_push, i_pop, i_afull_thr, i_aempty_thr, i_err_clr,
    input  o_wen, o_wptr, o_ren, o_rptr, o_full, o_empty,
           o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
  );

  modport slave (
    input  i_push, i_pop, i_afull_thr, i_aempty_thr, i_err_clr,
    output o_wen, o_wptr, o_ren, o_rptr, o_full, o_empty,
           o_almost_full, o_almost_empty, o_count, o_overflow, o_underflow
  );
endinterface

// File: rtl/sync_fifo_ctlr.sv
// sync_fifo_ctlr
//   Single-clock FIFO controller for an external simple-dual-port RAM. Produces
//   write/read addresses and enables, an occupancy count, full/empty flags and
//   run-time programmable almost-full/almost-empty flags. DEPTH need not be a
//   power of two; pointers wrap from DEPTH-1 to 0.
//
//   Ports:
//     i_clk  - clock
//     i_rst  - asynchronous, active-high reset
//     bus    - sync_fifo_ctlr_if.slave (requests, thresholds, err_clr in;
//              wen/wptr/ren/rptr, count, status flags out)
//
//   Build option:
//     SYNC_FIFO_ERR_EN - when defined, o_overflow / o_underflow are sticky
//                        error flags cleared by i_err_clr; when undefined they
//                        are tied low and i_err_clr is ignored.
//
//   Parameters: DEPTH >= 2, 2**AW >= DEPTH, 2**CW > DEPTH.
module sync_fifo_ctlr #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int CW    = 11
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sync_fifo_ctlr_if.slave      bus
);

  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_nxt;
  logic          full_q;
  logic          empty_q;
  logic          afull_q;
  logic          aempty_q;
  logic          push_ok;
  logic          pop_ok;

  // Acceptance looks only at the registered flags, so a pop in the same
  // cycle never rescues a push on a full FIFO (and vice versa when empty).
  assign push_ok = bus.i_push & ~full_q;
  assign pop_ok  = bus.i_pop  & ~empty_q;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_comb begin
    count_nxt = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + CW'(1);
      2'b01:   count_nxt = count_q - CW'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_ok) wptr_q <= ptr_inc(wptr_q);
      if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
    end
  end

  // Flags are re-evaluated every edge (not only on push/pop) so a threshold
  // change shows up one edge later even while the FIFO is idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      count_q  <= count_nxt;
      full_q   <= (count_nxt == CW'(DEPTH));
      empty_q  <= (count_nxt == '0);
      afull_q  <= (count_nxt >= bus.i_afull_thr);
      aempty_q <= (count_nxt <= bus.i_aempty_thr);
    end
  end

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // A new error in the same cycle as i_err_clr keeps the flag set.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.i_push & full_q)  overflow_q  <= 1'b1;
      else if (bus.i_err_clr)   overflow_q  <= 1'b0;
      if (bus.i_pop & empty_q)  underflow_q <= 1'b1;
      else if (bus.i_err_clr)   underflow_q <= 1'b0;
    end
  end

  assign bus.o_overflow  = overflow_q;
  assign bus.o_underflow = underflow_q;
`else
  assign bus.o_overflow  = 1'b0;
  assign bus.o_underflow = 1'b0;
`endif

  assign bus.o_wen          = push_ok;
  assign bus.o_ren          = pop_ok;
  assign bus.o_wptr         = wptr_q;
  assign bus.o_rptr         = rptr_q;
  assign bus.o_count        = count_q;
  assign bus.o_full         = full_q;
  assign bus.o_empty        = empty_q;
  assign bus.o_almost_full  = afull_q;
  assign bus.o_almost_empty = aempty_q;

endmodule

// File: tb/tb_sync_fifo_ctlr.sv
module tb_sync_fifo_ctlr;
  localparam int DEPTH = 5;
  localparam int AW    = 3;
  localparam int CW    = 4;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_rst;
  always #5 i_clk = ~i_clk;

  sync_fifo_ctlr_if #(.AW(AW), .CW(CW)) bus ();

  sync_fifo_ctlr #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  // exp_q holds, per stored entry, the RAM address it was written to; the
  // head of the queue is therefore the address the controller must read.
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] m_wptr, m_rptr;
  bit m_full, m_empty, m_af, m_ae, m_ov, m_un;

  task automatic model_reset();
    exp_q.delete();
    m_wptr = '0; m_rptr = '0;
    m_full = 0; m_empty = 1; m_af = 0; m_ae = 1; m_ov = 0; m_un = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply(input bit push, input bit pop);
    bus.i_push = push;
    bus.i_pop  = pop;
    #1;
  endtask

  task automatic clock_edge();
    bit pu, po, aw, ar;
    int n;
    @(posedge i_clk);
    if (i_rst) begin
      model_reset();
    end else begin
      pu = bus.i_push; po = bus.i_pop;
      aw = pu && !m_full;
      ar = po && !m_empty;
      if (ERR_EN) begin
        if (pu && m_full) m_ov = 1; else if (bus.i_err_clr) m_ov = 0;
        if (po && m_empty) m_un = 1; else if (bus.i_err_clr) m_un = 0;
      end
      if (ar) begin
        void'(exp_q.pop_front());
        m_rptr = AW'((int'(m_rptr) + 1) % DEPTH);
      end
      if (aw) begin
        exp_q.push_back(m_wptr);
        m_wptr = AW'((int'(m_wptr) + 1) % DEPTH);
      end
      n = exp_q.size();
      m_full  = (n == DEPTH);
      m_empty = (n == 0);
      m_af    = (n >= int'(bus.i_afull_thr));
      m_ae    = (n <= int'(bus.i_aempty_thr));
    end
    @(negedge i_clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1'b1;
    bus.i_push = 0; bus.i_pop = 0; bus.i_err_clr = 0;
    bus.i_afull_thr = CW'(4); bus.i_aempty_thr = CW'(1);
    model_reset();
    repeat (2) @(negedge i_clk);
    #1;
    n_vec++;
    if ({bus.o_count, bus.o_wptr, bus.o_rptr} !== {CW'(0), AW'(0), AW'(0)}) begin
      n_err++; $display("FAIL reset_count_ptrs: got %h expected 0", {bus.o_count, bus.o_wptr, bus.o_rptr});
    end
    n_vec++;
    if ({bus.o_full, bus.o_empty, bus.o_almost_full, bus.o_almost_empty, bus.o_overflow, bus.o_underflow} !== 6'b010100) begin
      n_err++; $display("FAIL reset_flags: got %b expected 010100",
        {bus.o_full, bus.o_empty, bus.o_almost_full, bus.o_almost_empty, bus.o_overflow, bus.o_underflow});
    end
    @(negedge i_clk);
    i_rst = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      apply(1, 0);
      n_vec++;
      if ({bus.o_wen, bus.o_wptr} !== {1'b1, AW'(i)}) begin
        n_err++; $display("FAIL fill_wptr[%0d]: wen/wptr got %b/%0d expected 1/%0d", i, bus.o_wen, bus.o_wptr, i);
      end
      clock_edge();
      #1;
      n_vec++;
      if (bus.o_count !== CW'(i + 1)) begin
        n_err++; $display("FAIL fill_count[%0d]: got %0d expected %0d", i, bus.o_count, i + 1);
      end
      n_vec++;
      if ({bus.o_full, bus.o_almost_full, bus.o_almost_empty} !== {(i + 1 == 5), (i + 1 >= 4), (i + 1 <= 1)}) begin
        n_err++; $display("FAIL fill_flags[%0d]: full/af/ae got %b%b%b expected %b%b%b", i,
          bus.o_full, bus.o_almost_full, bus.o_almost_empty, (i + 1 == 5), (i + 1 >= 4), (i + 1 <= 1));
      end
    end
    n_vec++;
    if (bus.o_wptr !== AW'(0)) begin
      n_err++; $display("FAIL fill_wrap: wptr got %0d expected 0", bus.o_wptr);
    end
  endtask

  task automatic test_overflow();
    apply(1, 0);
    n_vec++;
    if (bus.o_wen !== 1'b0) begin
      n_err++; $display("FAIL ovf_wen: got %b expected 0", bus.o_wen);
    end
    clock_edge();
    apply(0, 0);
    n_vec++;
    if ({bus.o_count, bus.o_overflow} !== {CW'(5), ERR_EN}) begin
      n_err++; $display("FAIL ovf_flag: count/ovf got %0d/%b expected 5/%b", bus.o_count, bus.o_overflow, ERR_EN);
    end
    bus.i_err_clr = 1;
    clock_edge();
    bus.i_err_clr = 0;
    #1;
    n_vec++;
    if (bus.o_overflow !== 1'b0) begin
      n_err++; $display("FAIL ovf_clr: got %b expected 0", bus.o_overflow);
    end
  endtask

  task automatic test_back_to_back();
    repeat (2) begin apply(0, 1); clock_edge(); end
    for (int i = 0; i < 10; i++) begin
      apply(1, 1);
      n_vec++;
      if ({bus.o_wen, bus.o_ren, bus.o_rptr, bus.o_wptr} !== {2'b11, exp_q[0], m_wptr}) begin
        n_err++; $display("FAIL b2b_ptrs[%0d]: wen/ren/rptr/wptr got %b%b/%0d/%0d expected 11/%0d/%0d",
          i, bus.o_wen, bus.o_ren, bus.o_rptr, bus.o_wptr, exp_q[0], m_wptr);
      end
      clock_edge();
      #1;
      n_vec++;
      if ({bus.o_count, bus.o_full, bus.o_empty, bus.o_almost_full, bus.o_almost_empty} !== {CW'(3), 4'b0000}) begin
        n_err++; $display("FAIL b2b_hold[%0d]: count/flags got %0d/%b expected 3/0000", i, bus.o_count,
          {bus.o_full, bus.o_empty, bus.o_almost_full, bus.o_almost_empty});
      end
    end
  endtask

  task automatic test_empty_boundary();
    repeat (3) begin apply(0, 1); clock_edge(); end
    apply(1, 1);
    n_vec++;
    if ({bus.o_empty, bus.o_wen, bus.o_ren} !== 3'b110) begin
      n_err++; $display("FAIL empty_enables: empty/wen/ren got %b%b%b expected 110", bus.o_empty, bus.o_wen, bus.o_ren);
    end
    clock_edge();
    apply(0, 0);
    n_vec++;
    if ({bus.o_count, bus.o_empty, bus.o_underflow} !== {CW'(1), 1'b0, ERR_EN}) begin
      n_err++; $display("FAIL empty_after: count/empty/udf got %0d/%b/%b expected 1/0/%b",
        bus.o_count, bus.o_empty, bus.o_underflow, ERR_EN);
    end
    bus.i_err_clr = 1;
    clock_edge();
    bus.i_err_clr = 0;
  endtask

  task automatic test_async_reset();
    repeat (2) begin apply(1, 0); clock_edge(); end
    apply(0, 0);
    #1;
    i_rst = 1'b1;
    model_reset();
    #1;
    n_vec++;
    if ({bus.o_count, bus.o_wptr, bus.o_rptr, bus.o_empty, bus.o_almost_empty, bus.o_full, bus.o_almost_full}
        !== {CW'(0), AW'(0), AW'(0), 4'b1100}) begin
      n_err++; $display("FAIL async_reset: count/wptr/rptr got %0d/%0d/%0d flags %b%b%b%b expected 0/0/0 1100",
        bus.o_count, bus.o_wptr, bus.o_rptr, bus.o_empty, bus.o_almost_empty, bus.o_full, bus.o_almost_full);
    end
    @(negedge i_clk);
    apply(0, 1);
    n_vec++;
    if (bus.o_ren !== 1'b0) begin
      n_err++; $display("FAIL reset_ren: got %b expected 0", bus.o_ren);
    end
    clock_edge();
    i_rst = 1'b0;
    apply(1, 0);
    n_vec++;
    if ({bus.o_wen, bus.o_wptr} !== {1'b1, AW'(0)}) begin
      n_err++; $display("FAIL post_reset_push: wen/wptr got %b/%0d expected 1/0", bus.o_wen, bus.o_wptr);
    end
    clock_edge();
  endtask

  task automatic test_threshold();
    apply(1, 0); clock_edge();
    apply(0, 0);
    bus.i_afull_thr = CW'(2);
    #1;
    n_vec++;
    if ({bus.o_count, bus.o_almost_full} !== {CW'(2), 1'b0}) begin
      n_err++; $display("FAIL thr_before: count/af got %0d/%b expected 2/0", bus.o_count, bus.o_almost_full);
    end
    clock_edge();
    #1;
    n_vec++;
    if (bus.o_almost_full !== 1'b1) begin
      n_err++; $display("FAIL thr_after: af got %b expected 1", bus.o_almost_full);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] e_rptr;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) bus.i_afull_thr  = CW'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.i_aempty_thr = CW'($urandom_range(0, 15));
      bus.i_err_clr = ($urandom_range(0, 7) == 0);
      apply(($urandom_range(0, 99) < 55), ($urandom_range(0, 99) < 50));
      e_rptr = (exp_q.size() != 0) ? exp_q[0] : m_rptr;
      n_vec++;
      if ({bus.o_wen, bus.o_ren, bus.o_full, bus.o_empty, bus.o_almost_full, bus.o_almost_empty,
           bus.o_overflow, bus.o_underflow, bus.o_count, bus.o_wptr, bus.o_rptr} !==
          {bus.i_push & ~m_full, bus.i_pop & ~m_empty, m_full, m_empty, m_af, m_ae, m_ov, m_un,
           CW'(exp_q.size()), m_wptr, e_rptr}) begin
        n_err++;
        $display("FAIL random[%0d]: wen,ren,full,empty,af,ae,ovf,udf=%b count=%0d wptr=%0d rptr=%0d; expected %b count=%0d wptr=%0d rptr=%0d",
          i, {bus.o_wen, bus.o_ren, bus.o_full, bus.o_empty, bus.o_almost_full, bus.o_almost_empty, bus.o_overflow, bus.o_underflow},
          bus.o_count, bus.o_wptr, bus.o_rptr,
          {bus.i_push & ~m_full, bus.i_pop & ~m_empty, m_full, m_empty, m_af, m_ae, m_ov, m_un},
          exp_q.size(), m_wptr, e_rptr);
      end
      clock_edge();
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_back_to_back();
    test_empty_boundary();
    test_async_reset();
    test_threshold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got time limit expected finish");
    $fatal(1);
  end
endmodule
